// File: rtl/cp0_exc_seq.sv
// Exception/ERET sequencer driving the single CP0 read/write port.
// Runs Status RMW plus EPC write/read, then flushes and redirects.
module cp0_exc_seq #(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
    parameter logic [4:0]  STATUS_ADDR = 5'd12,
    parameter logic [4:0]  EPC_ADDR    = 5'd14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_req,
    input  logic        exc_eret,
    input  logic [31:0] exc_pc,
    input  logic        exc_delayslot,
    output logic        busy,
    output logic        flush,
    output logic        exc_ack,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [4:0]  cp0_read_addr,
    input  logic [31:0] cp0_read_data,
    output logic        cp0_write_en,
    output logic [4:0]  cp0_write_addr,
    output logic [31:0] cp0_write_data
);

    typedef enum logic [2:0] {
        IDLE,
        STAT_RD,
        STAT_WR,
        EPC_WR,
        EPC_RD,
        DONE
    } state_t;

    state_t      state;
    logic        eret_q;
    logic        exl_q;
    logic [31:0] epc_val_q;

    // Sequencer: outputs are loaded on the edge entering the state
    // in which they must be visible, so every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            eret_q         <= 1'b0;
            exl_q          <= 1'b0;
            epc_val_q      <= 32'd0;
            busy           <= 1'b0;
            flush          <= 1'b0;
            exc_ack        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            cp0_read_addr  <= 5'd0;
            cp0_write_en   <= 1'b0;
            cp0_write_addr <= 5'd0;
            cp0_write_data <= 32'd0;
        end else begin
            exc_ack        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            cp0_read_addr  <= 5'd0;
            cp0_write_en   <= 1'b0;
            cp0_write_addr <= 5'd0;
            cp0_write_data <= 32'd0;
            unique case (state)
                IDLE: begin
                    if (exc_req) begin
                        state         <= STAT_RD;
                        busy          <= 1'b1;
                        flush         <= 1'b1;
                        cp0_read_addr <= STATUS_ADDR;
                        eret_q        <= exc_eret;
                        epc_val_q     <= exc_delayslot ?
                                         exc_pc - 32'd4 : exc_pc;
                    end
                end
                STAT_RD: begin
                    state          <= STAT_WR;
                    exl_q          <= cp0_read_data[1];
                    cp0_write_en   <= 1'b1;
                    cp0_write_addr <= STATUS_ADDR;
                    cp0_write_data <= eret_q ?
                                      (cp0_read_data & ~32'h2) :
                                      (cp0_read_data | 32'h2);
                end
                STAT_WR: begin
                    if (eret_q) begin
                        state         <= EPC_RD;
                        cp0_read_addr <= EPC_ADDR;
                    end else if (exl_q) begin
                        // Nested: keep the original EPC.
                        state          <= DONE;
                        exc_ack        <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= EXC_VECTOR;
                    end else begin
                        state          <= EPC_WR;
                        cp0_write_en   <= 1'b1;
                        cp0_write_addr <= EPC_ADDR;
                        cp0_write_data <= epc_val_q;
                    end
                end
                EPC_WR: begin
                    state          <= DONE;
                    exc_ack        <= 1'b1;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= EXC_VECTOR;
                end
                EPC_RD: begin
                    state          <= DONE;
                    exc_ack        <= 1'b1;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= cp0_read_data;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    flush <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    flush <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Randomized bench for cp0_exc_seq against a CP0 register model
// and a per-cycle transaction expectation.
module tb_cp0_exc_seq;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_req;
    logic        exc_eret;
    logic [31:0] exc_pc;
    logic        exc_delayslot;
    logic        busy;
    logic        flush;
    logic        exc_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [4:0]  cp0_read_addr;
    logic [31:0] cp0_read_data;
    logic        cp0_write_en;
    logic [4:0]  cp0_write_addr;
    logic [31:0] cp0_write_data;

    logic [31:0] regs [32];
    logic        pl_en = 1'b0;
    logic [31:0] pl_stat = 32'd0;
    logic [31:0] pl_epc = 32'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cp0_exc_seq dut (
        .clk            (clk),
        .rst            (rst),
        .exc_req        (exc_req),
        .exc_eret       (exc_eret),
        .exc_pc         (exc_pc),
        .exc_delayslot  (exc_delayslot),
        .busy           (busy),
        .flush          (flush),
        .exc_ack        (exc_ack),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .cp0_read_addr  (cp0_read_addr),
        .cp0_read_data  (cp0_read_data),
        .cp0_write_en   (cp0_write_en),
        .cp0_write_addr (cp0_write_addr),
        .cp0_write_data (cp0_write_data)
    );

    // CP0 register file model: combinational read, write at edge.
    assign cp0_read_data = regs[cp0_read_addr];

    always @(posedge clk) begin
        if (pl_en) begin
            regs[12] <= pl_stat;
            regs[14] <= pl_epc;
        end else if (cp0_write_en) begin
            regs[cp0_write_addr] <= cp0_write_data;
        end
    end

    function automatic logic [78:0] pack(
        input logic b, input logic f, input logic a, input logic rv,
        input logic [31:0] rpc, input logic [4:0] ra,
        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        return {b, f, a, rv, rpc, ra, we, wa, wd};
    endfunction

    function automatic logic [78:0] obs();
        return pack(busy, flush, exc_ack, redirect_valid, redirect_pc,
                    cp0_read_addr, cp0_write_en, cp0_write_addr,
                    cp0_write_data);
    endfunction

    task automatic chk(input string tag, input logic [78:0] got,
                       input logic [78:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] st, input logic [31:0] ep);
        pl_stat = st;
        pl_epc  = ep;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Starts at a negedge in an idle cycle, ends at the negedge of
    // the first idle cycle after DONE (or after reset if rst_at>0).
    task automatic run_seq(input string tag, input logic eret,
                           input logic [31:0] pc, input logic ds,
                           input bit inject, input int rst_at);
        logic [31:0] st;
        logic [31:0] ep;
        logic [31:0] epc_new;
        logic [31:0] st_new;
        logic [78:0] e;
        bit          nested;
        int          len;
        st      = regs[12];
        ep      = regs[14];
        nested  = !eret && st[1];
        epc_new = ds ? pc - 32'd4 : pc;
        st_new  = eret ? (st & ~32'h2) : (st | 32'h2);
        len     = nested ? 3 : 4;
        chk({tag, "_idle"}, obs(), '0);
        exc_eret      = eret;
        exc_pc        = pc;
        exc_delayslot = ds;
        exc_req       = 1'b1;
        @(negedge clk);
        exc_req = 1'b0;
        for (int k = 1; k <= len; k++) begin
            if (k == len)
                e = pack(1, 1, 1, 1, eret ? ep : VEC, 0, 0, 0, 0);
            else if (k == 1)
                e = pack(1, 1, 0, 0, 0, 12, 0, 0, 0);
            else if (k == 2)
                e = pack(1, 1, 0, 0, 0, 0, 1, 12, st_new);
            else if (eret)
                e = pack(1, 1, 0, 0, 0, 14, 0, 0, 0);
            else
                e = pack(1, 1, 0, 0, 0, 0, 1, 14, epc_new);
            chk($sformatf("%s_c%0d", tag, k), obs(), e);
            exc_req = inject && (k == 2);
            if (inject && k == 2) begin
                exc_eret = $urandom_range(0, 1);
                exc_pc   = $urandom;
            end
            if (rst_at == k) begin
                rst = 1'b1;
                @(negedge clk);
                exc_req = 1'b0;
                rst = 1'b0;
                chk({tag, "_rstout"}, obs(), '0);
                chk({tag, "_rststat"}, {47'd0, regs[12]}, {47'd0, st_new});
                chk({tag, "_rstepc"}, {47'd0, regs[14]}, {47'd0, ep});
                @(negedge clk);
                chk({tag, "_rstidle"}, obs(), '0);
                return;
            end
            @(negedge clk);
        end
        exc_req = 1'b0;
        chk({tag, "_stat"}, {47'd0, regs[12]}, {47'd0, st_new});
        chk({tag, "_epc"}, {47'd0, regs[14]},
            {47'd0, (!eret && !nested) ? epc_new : ep});
    endtask

    initial begin
        rst           = 1'b1;
        exc_req       = 1'b0;
        exc_eret      = 1'b0;
        exc_pc        = 32'd0;
        exc_delayslot = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("reset", obs(), '0);
        rst = 1'b0;
        @(negedge clk);

        preload(32'h0000_FF00, 32'h1111_1111);
        run_seq("exc", 0, 32'h8000_1000, 0, 0, 0);
        preload(32'h0000_FF00, 32'h1111_1111);
        run_seq("ds", 0, 32'h8000_2004, 1, 0, 0);
        preload(32'h0000_0000, 32'h1111_1111);
        run_seq("ds0", 0, 32'h0000_0000, 1, 0, 0);
        preload(32'h0000_0003, 32'h2222_2222);
        run_seq("nest", 0, 32'h8000_5000, 0, 0, 0);
        preload(32'h0000_FF03, 32'h8000_3000);
        run_seq("eret", 1, 32'h8000_4444, 0, 0, 0);
        preload(32'h0000_FF00, 32'h1111_1111);
        run_seq("inj", 0, 32'h8000_6000, 0, 1, 0);
        run_seq("b2b", 1, 32'h0, 0, 0, 0);
        preload(32'h0000_FF00, 32'h3333_3333);
        run_seq("rst", 0, 32'h8000_7000, 0, 0, 2);
        run_seq("post", 0, 32'h8000_7100, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) != 0)
                preload($urandom, $urandom);
            run_seq($sformatf("r%0d", n), 1'($urandom_range(0, 1)),
                    $urandom, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) == 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
